// File: rtl/tlu_pkg.sv
// Shared definitions for the TLU run-sequencing controller: default widths,
// channel count and the run state encoding.
package tlu_pkg;

    localparam int TLU_CNT_W = 32;
    localparam int TLU_TMR_W = 16;
    localparam int TLU_N_DUT = 6;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARMING   = 3'd1,
        ST_RUNNING  = 3'd2,
        ST_DEADTIME = 3'd3,
        ST_DRAINING = 3'd4,
        ST_DONE     = 3'd5
    } tlu_state_e;

endpackage

// File: rtl/tlu_load_timer.sv
// Loadable down-counter with an is-zero flag; shared between the arm delay and
// the dead-time because the two are never running at the same time.
module tlu_load_timer #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // Load has priority over decrement; the count parks at zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tlu_run_ctrl.sv
// Run-sequencing controller: turns coincidence trigger requests into granted
// triggers while managing arm delay, dead-time, trigger limit and drain.
module tlu_run_ctrl
    import tlu_pkg::*;
#(
    parameter int CNT_W = TLU_CNT_W,
    parameter int TMR_W = TLU_TMR_W,
    parameter int N_DUT = TLU_N_DUT
) (
    input  logic             CLK40,
    input  logic             RST_N,
    input  logic             CMD_START,
    input  logic             CMD_STOP,
    input  logic             CMD_ABORT,
    input  logic [TMR_W-1:0] CONF_ARM_DELAY,
    input  logic [TMR_W-1:0] CONF_DEADTIME,
    input  logic [CNT_W-1:0] CONF_MAX_TRIGGERS,
    input  logic [N_DUT-1:0] CONF_EN_OUTPUT,
    input  logic [N_DUT-1:0] DUT_READY,
    input  logic             FIFO_FULL,
    input  logic             TRIG_REQ,
    output logic             TRIG_GRANT,
    output logic             TS_CLEAR,
    output logic             RUN_ACTIVE,
    output logic             RUN_DONE,
    output logic [2:0]       STATE,
    output logic [CNT_W-1:0] TRIG_CNT,
    output logic [CNT_W-1:0] SKIP_CNT
);

    tlu_state_e       state_q, state_d;
    logic             trig_grant_q, ts_clear_q, run_active_q, run_done_q;
    logic [CNT_W-1:0] trig_cnt_q, skip_cnt_q, trig_cnt_inc_s;
    logic             all_ready_s, start_ok_s, accept_s, reject_s, hit_max_s;
    logic             tmr_load_s, tmr_dec_s, tmr_last_s, tmr_zero_s;
    logic [TMR_W-1:0] tmr_val_s, tmr_cnt_s;

    tlu_load_timer #(.W(TMR_W)) u_timer (
        .clk_i      (CLK40),
        .rst_ni     (RST_N),
        .load_i     (tmr_load_s),
        .load_val_i (tmr_val_s),
        .dec_i      (tmr_dec_s),
        .cnt_o      (tmr_cnt_s),
        .zero_o     (tmr_zero_s)
    );

    // Request qualification and timer control; stop and abort both mask requests.
    always_comb begin
        all_ready_s    = &(DUT_READY | ~CONF_EN_OUTPUT);
        start_ok_s     = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && CMD_START && !CMD_ABORT;
        accept_s       = (state_q == ST_RUNNING) && TRIG_REQ && all_ready_s && !FIFO_FULL
                         && !CMD_STOP && !CMD_ABORT;
        reject_s       = (((state_q == ST_RUNNING) && !(all_ready_s && !FIFO_FULL))
                         || (state_q == ST_DEADTIME)) && TRIG_REQ && !CMD_STOP && !CMD_ABORT;
        trig_cnt_inc_s = trig_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        hit_max_s      = (CONF_MAX_TRIGGERS != '0) && (trig_cnt_inc_s == CONF_MAX_TRIGGERS);
        tmr_load_s     = start_ok_s || (accept_s && !hit_max_s && (CONF_DEADTIME != '0));
        if (start_ok_s) begin
            tmr_val_s = CONF_ARM_DELAY;
        end else begin
            tmr_val_s = CONF_DEADTIME;
        end
        tmr_dec_s  = (state_q == ST_ARMING) || (state_q == ST_DEADTIME);
        tmr_last_s = tmr_zero_s || (tmr_cnt_s == {{(TMR_W-1){1'b0}}, 1'b1});
    end

    // Next-state decode; abort overrides every other command.
    always_comb begin
        state_d = state_q;
        if (CMD_ABORT) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (CMD_START) state_d = ST_ARMING;
                    else           state_d = state_q;
                end
                ST_ARMING: begin
                    if (CMD_STOP)        state_d = ST_DRAINING;
                    else if (tmr_last_s) state_d = ST_RUNNING;
                    else                 state_d = ST_ARMING;
                end
                ST_RUNNING: begin
                    if (CMD_STOP)                      state_d = ST_DRAINING;
                    else if (accept_s && hit_max_s)    state_d = ST_DRAINING;
                    else if (accept_s && (CONF_DEADTIME != '0)) state_d = ST_DEADTIME;
                    else                               state_d = ST_RUNNING;
                end
                ST_DEADTIME: begin
                    if (CMD_STOP)        state_d = ST_DRAINING;
                    else if (tmr_last_s) state_d = ST_RUNNING;
                    else                 state_d = ST_DEADTIME;
                end
                ST_DRAINING: begin
                    if (all_ready_s) state_d = ST_DONE;
                    else             state_d = ST_DRAINING;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, registered status outputs and run counters.
    always_ff @(posedge CLK40 or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            trig_grant_q <= 1'b0;
            ts_clear_q   <= 1'b0;
            run_active_q <= 1'b0;
            run_done_q   <= 1'b0;
            trig_cnt_q   <= '0;
            skip_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            trig_grant_q <= accept_s;
            ts_clear_q   <= start_ok_s;
            run_active_q <= (state_d inside {ST_ARMING, ST_RUNNING, ST_DEADTIME, ST_DRAINING});
            run_done_q   <= (state_d == ST_DONE);
            if (start_ok_s) begin
                trig_cnt_q <= '0;
                skip_cnt_q <= '0;
            end else begin
                if (accept_s) begin
                    trig_cnt_q <= trig_cnt_inc_s;
                end
                if (reject_s && !(&skip_cnt_q)) begin
                    skip_cnt_q <= skip_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign TRIG_GRANT = trig_grant_q;
    assign TS_CLEAR   = ts_clear_q;
    assign RUN_ACTIVE = run_active_q;
    assign RUN_DONE   = run_done_q;
    assign STATE      = state_q;
    assign TRIG_CNT   = trig_cnt_q;
    assign SKIP_CNT   = skip_cnt_q;

endmodule

// File: tb/tb_tlu_run_ctrl.sv
// Scoreboard bench for tlu_run_ctrl: stimulus queues expected grant/TS_CLEAR
// cycles, a negedge monitor pops and compares them as the DUT produces pulses.
module tb_tlu_run_ctrl;

    localparam int CNT_W = 32;
    localparam int TMR_W = 16;
    localparam int N_DUT = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_start, cmd_stop, cmd_abort, fifo_full, trig_req;
    logic [TMR_W-1:0] conf_arm, conf_dead;
    logic [CNT_W-1:0] conf_max;
    logic [N_DUT-1:0] conf_en, dut_ready;
    logic             trig_grant, ts_clear, run_active, run_done;
    logic [2:0]       state;
    logic [CNT_W-1:0] trig_cnt, skip_cnt;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int gq_cyc[$];
    int gq_cnt[$];
    int tq_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tlu_run_ctrl dut (
        .CLK40(clk), .RST_N(rst_n),
        .CMD_START(cmd_start), .CMD_STOP(cmd_stop), .CMD_ABORT(cmd_abort),
        .CONF_ARM_DELAY(conf_arm), .CONF_DEADTIME(conf_dead),
        .CONF_MAX_TRIGGERS(conf_max), .CONF_EN_OUTPUT(conf_en),
        .DUT_READY(dut_ready), .FIFO_FULL(fifo_full), .TRIG_REQ(trig_req),
        .TRIG_GRANT(trig_grant), .TS_CLEAR(ts_clear), .RUN_ACTIVE(run_active),
        .RUN_DONE(run_done), .STATE(state), .TRIG_CNT(trig_cnt), .SKIP_CNT(skip_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_grant(input int at, input int cnt);
        gq_cyc.push_back(at);
        gq_cnt.push_back(cnt);
    endtask

    // Monitor: every grant / TS_CLEAR pulse must match the head of its queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (trig_grant) begin
                if (gq_cyc.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_grant: grant seen at cycle %0d, none expected", cyc);
                end else begin
                    chk("grant_cycle", cyc, gq_cyc.pop_front());
                    chk("grant_trig_cnt", trig_cnt, gq_cnt.pop_front());
                end
            end else if (gq_cyc.size() > 0 && gq_cyc[0] <= cyc) begin
                chk("grant_present", trig_grant, 1);
                void'(gq_cyc.pop_front());
                void'(gq_cnt.pop_front());
            end
            if (ts_clear) begin
                if (tq_cyc.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_ts_clear: pulse at cycle %0d, none expected", cyc);
                end else begin
                    chk("ts_clear_cycle", cyc, tq_cyc.pop_front());
                end
            end else if (tq_cyc.size() > 0 && tq_cyc[0] <= cyc) begin
                chk("ts_clear_present", ts_clear, 1);
                void'(tq_cyc.pop_front());
            end
        end
    end

    initial begin
        int c0;
        int ntrig;
        cmd_start = 1'b0; cmd_stop = 1'b0; cmd_abort = 1'b0;
        fifo_full = 1'b0; trig_req = 1'b0;
        conf_arm = 16'd0; conf_dead = 16'd0; conf_max = 32'd0;
        conf_en = 6'h3F; dut_ready = 6'h3F;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_flags", {trig_grant, ts_clear, run_active, run_done, state}, 0);
        chk("reset_trig_cnt", trig_cnt, 0);
        chk("reset_skip_cnt", skip_cnt, 0);
        rst_n = 1'b1;
        step();

        // Arm delay 3, request every cycle, no dead-time.
        conf_arm = 16'd3; cmd_start = 1'b1; trig_req = 1'b1;
        c0 = cyc; tq_cyc.push_back(cyc + 1); ntrig = 0;
        step();
        cmd_start = 1'b0;
        chk("arming_state", state, 1);
        chk("arming_active", run_active, 1);
        while (cyc < c0 + 10) begin
            if (cyc >= c0 + 4) begin
                ntrig++;
                push_grant(cyc + 1, ntrig);
            end
            step();
        end
        chk("t1_trig_cnt", trig_cnt, 6);
        chk("t1_skip_cnt", skip_cnt, 0);

        // Stop together with a request.
        cmd_stop = 1'b1;
        step();
        cmd_stop = 1'b0; trig_req = 1'b0;
        chk("stop_state", state, 4);
        chk("stop_trig_cnt", trig_cnt, 6);
        chk("stop_skip_cnt", skip_cnt, 0);
        step();
        chk("done_state", state, 5);
        chk("done_flags", {run_active, run_done}, 2'b01);

        // Dead-time 4, zero arm delay, 20 request cycles.
        conf_arm = 16'd0; conf_dead = 16'd4; cmd_start = 1'b1;
        tq_cyc.push_back(cyc + 1);
        step();
        cmd_start = 1'b0;
        step();
        chk("t2_running", state, 2);
        trig_req = 1'b1; ntrig = 0;
        for (int k = 0; k < 20; k++) begin
            if (k % 5 == 0) begin
                ntrig++;
                push_grant(cyc + 1, ntrig);
            end
            step();
        end
        trig_req = 1'b0;
        chk("t2_trig_cnt", trig_cnt, 4);
        chk("t2_skip_cnt", skip_cnt, 16);
        chk("t2_state", state, 2);

        // FIFO full, then an enabled channel not ready, then that channel disabled.
        conf_dead = 16'd0; fifo_full = 1'b1; trig_req = 1'b1;
        repeat (3) step();
        fifo_full = 1'b0; dut_ready = 6'b111110;
        repeat (3) step();
        chk("veto_skip_cnt", skip_cnt, 22);
        chk("veto_trig_cnt", trig_cnt, 4);
        conf_en = 6'b111110;
        push_grant(cyc + 1, 5);
        step();
        chk("disabled_ch_trig_cnt", trig_cnt, 5);
        chk("disabled_ch_skip_cnt", skip_cnt, 22);

        // Abort with a simultaneous request.
        conf_en = 6'h3F; dut_ready = 6'h3F; cmd_abort = 1'b1;
        step();
        cmd_abort = 1'b0; trig_req = 1'b0;
        chk("abort_state", state, 0);
        chk("abort_grant", trig_grant, 0);
        chk("abort_active", run_active, 0);
        chk("abort_hold_cnts", {trig_cnt, skip_cnt}, {32'd5, 32'd22});

        // Trigger limit 2, channel 1 stalls the drain.
        conf_max = 32'd2; conf_en = 6'b000011; cmd_start = 1'b1;
        tq_cyc.push_back(cyc + 1);
        step();
        cmd_start = 1'b0;
        step();
        trig_req = 1'b1;
        push_grant(cyc + 1, 1);
        step();
        push_grant(cyc + 1, 2);
        step();
        dut_ready = 6'b111101;
        repeat (3) step();
        chk("drain_state", state, 4);
        chk("drain_active", run_active, 1);
        dut_ready = 6'h3F;
        step();
        chk("limit_done_state", state, 5);
        chk("limit_run_done", run_done, 1);
        repeat (2) step();
        chk("limit_trig_cnt", trig_cnt, 2);
        chk("limit_skip_cnt", skip_cnt, 0);
        trig_req = 1'b0; conf_max = 32'd0; conf_en = 6'h3F;

        // Reset during dead-time.
        conf_dead = 16'd10; cmd_start = 1'b1;
        tq_cyc.push_back(cyc + 1);
        step();
        cmd_start = 1'b0;
        step();
        trig_req = 1'b1;
        push_grant(cyc + 1, 1);
        step();
        trig_req = 1'b0;
        step();
        chk("deadtime_state", state, 3);
        rst_n = 1'b0;
        #1;
        chk("midrst_flags", {trig_grant, ts_clear, run_active, run_done, state}, 0);
        chk("midrst_cnts", {trig_cnt, skip_cnt}, 0);
        #2;
        rst_n = 1'b1;
        step();
        conf_dead = 16'd0; cmd_start = 1'b1;
        tq_cyc.push_back(cyc + 1);
        step();
        cmd_start = 1'b0;
        chk("restart_state", state, 1);
        chk("restart_trig_cnt", trig_cnt, 0);

        repeat (3) step();
        chk("grant_queue_drained", gq_cyc.size(), 0);
        chk("ts_queue_drained", tq_cyc.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
